// File: rtl/sseg_pkg.sv
// Shared word layout and BCD types for the seven-segment digit path.
package sseg_pkg;

  localparam int unsigned WORD_W     = 6;
  localparam int unsigned EN_BIT     = 5;
  localparam int unsigned HEX_MSB    = 4;
  localparam int unsigned HEX_LSB    = 1;
  localparam int unsigned DP_BIT     = 0;
  localparam int unsigned MAX_DIGITS = 8;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade: steps up or down when enabled and its carry/borrow input is set.
module bcd_decade
  import sseg_pkg::*;
(
  input  logic clk,
  input  logic en,
  input  logic up,
  input  logic cin,
  input  logic clr,
  output bcd_t q,
  output logic cout
);

  bcd_t q_q, q_d;

  // Carry out is a pure function of the request and current value so the
  // whole chain settles within one cycle.
  assign cout = cin & (up ? (q_q == BCD_MAX) : (q_q == '0));

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en && cin) begin
      if (up) q_d = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
      else    q_d = (q_q == '0) ? BCD_MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/bcd_event_counter.sv
// Up/down BCD event counter feeding registered seven-segment digit words.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module bcd_event_counter
  import sseg_pkg::*;
#(
  parameter int unsigned DIGITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_tick,
  input  logic              dec_tick,
  input  logic              clear,
  input  logic [7:0]        dp_mask,
  output logic [WORD_W-1:0] I0,
  output logic [WORD_W-1:0] I1,
  output logic [WORD_W-1:0] I2,
  output logic [WORD_W-1:0] I3,
  output logic [WORD_W-1:0] I4,
  output logic [WORD_W-1:0] I5,
  output logic [WORD_W-1:0] I6,
  output logic [WORD_W-1:0] I7,
  output logic              wrap
);

  logic              tick;
  logic              dec_clr;
  logic [DIGITS:0]   carry;
  bcd_t              digit [MAX_DIGITS];
  logic              wrap_q, wrap_d;
  logic [WORD_W-1:0] words_q [MAX_DIGITS];
  logic [WORD_W-1:0] words_d [MAX_DIGITS];

  assign tick     = inc_tick ^ dec_tick;
  assign dec_clr  = reset | clear;
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < MAX_DIGITS; g++) begin : g_dec
    if (g < DIGITS) begin : g_on
      bcd_decade u_decade (
        .clk  (clk),
        .en   (tick),
        .up   (inc_tick),
        .cin  (carry[g]),
        .clr  (dec_clr),
        .q    (digit[g]),
        .cout (carry[g+1])
      );
    end else begin : g_off
      assign digit[g] = '0;
    end
  end

  assign wrap_d = tick & carry[DIGITS] & ~clear;

  function automatic logic [WORD_W-1:0] reset_word(input int unsigned k);
    logic [WORD_W-1:0] r;
    r = '0;
`ifdef LEADING_ZERO_BLANK_EN
    r[EN_BIT] = (k == 0);
`else
    r[EN_BIT] = (k < DIGITS);
`endif
    return r;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // show[k] is set when decade k or any higher decade is non-zero.
  logic [MAX_DIGITS-1:0] show;
  always_comb begin
    logic seen;
    seen = 1'b0;
    show = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      seen = seen | (digit[MAX_DIGITS-1-i] != '0);
      show[MAX_DIGITS-1-i] = seen;
    end
  end
`endif

  always_comb begin
    for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
      words_d[k] = '0;
      if (k < DIGITS) begin
        words_d[k][HEX_MSB:HEX_LSB] = digit[k];
        words_d[k][DP_BIT]          = dp_mask[k];
`ifdef LEADING_ZERO_BLANK_EN
        words_d[k][EN_BIT]          = (k == 0) | show[k] | dp_mask[k];
`else
        words_d[k][EN_BIT]          = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
      for (int unsigned k = 0; k < MAX_DIGITS; k++) words_q[k] <= reset_word(k);
    end else begin
      wrap_q <= wrap_d;
      for (int unsigned k = 0; k < MAX_DIGITS; k++) words_q[k] <= words_d[k];
    end
  end

  assign I0   = words_q[0];
  assign I1   = words_q[1];
  assign I2   = words_q[2];
  assign I3   = words_q[3];
  assign I4   = words_q[4];
  assign I5   = words_q[5];
  assign I6   = words_q[6];
  assign I7   = words_q[7];
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_event_counter.sv
// Self-checking bench: DIGITS=8 and DIGITS=4 instances against a decimal-arithmetic model.
module tb_bcd_event_counter;

  logic       clk = 1'b0;
  logic       reset, inc_tick, dec_tick, clear;
  logic [7:0] dp_mask;
  logic [5:0] o8 [8];
  logic [5:0] o4 [8];
  logic       w8, w4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_event_counter #(.DIGITS(8)) u8 (
    .clk(clk), .reset(reset), .inc_tick(inc_tick), .dec_tick(dec_tick), .clear(clear),
    .dp_mask(dp_mask), .I0(o8[0]), .I1(o8[1]), .I2(o8[2]), .I3(o8[3]), .I4(o8[4]),
    .I5(o8[5]), .I6(o8[6]), .I7(o8[7]), .wrap(w8)
  );

  bcd_event_counter #(.DIGITS(4)) u4 (
    .clk(clk), .reset(reset), .inc_tick(inc_tick), .dec_tick(dec_tick), .clear(clear),
    .dp_mask(dp_mask), .I0(o4[0]), .I1(o4[1]), .I2(o4[2]), .I3(o4[3]), .I4(o4[4]),
    .I5(o4[5]), .I6(o4[6]), .I7(o4[7]), .wrap(w4)
  );

  // Reference model: the count is an ordinary integer modulo 10**DIGITS.
  longint     cnt_m [2];
  int         dig_m [2] = '{8, 4};
  logic [5:0] exp_w [2][8];
  logic       exp_wrap [2];
  bit         model_valid = 0;

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [5:0] model_word(input int k, input longint cnt,
                                            input logic [7:0] dp, input int d);
    logic [5:0] w;
    longint     digit;
    if (k >= d) return 6'd0;
    digit = (cnt / pow10(k)) % 10;
    w[4:1] = digit[3:0];
    w[0]   = dp[k];
`ifdef LEADING_ZERO_BLANK_EN
    w[5] = (k == 0) || (cnt >= pow10(k)) || dp[k];
`else
    w[5] = 1'b1;
`endif
    return w;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      longint mx;
      bit     wr;
      mx = pow10(dig_m[i]) - 1;
      wr = 0;
      if (reset) begin
        cnt_m[i] = 0;
        for (int k = 0; k < 8; k++) exp_w[i][k] = model_word(k, 0, 8'h00, dig_m[i]);
        exp_wrap[i] = 1'b0;
      end else begin
        for (int k = 0; k < 8; k++) exp_w[i][k] = model_word(k, cnt_m[i], dp_mask, dig_m[i]);
        if (clear) cnt_m[i] = 0;
        else if (inc_tick && !dec_tick) begin
          if (cnt_m[i] == mx) begin cnt_m[i] = 0; wr = 1; end
          else cnt_m[i] = cnt_m[i] + 1;
        end else if (dec_tick && !inc_tick) begin
          if (cnt_m[i] == 0) begin cnt_m[i] = mx; wr = 1; end
          else cnt_m[i] = cnt_m[i] - 1;
        end
        exp_wrap[i] = wr;
      end
    end
    if (reset) model_valid = 1;
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < 8; k++) begin
        check($sformatf("u8.I%0d", k), {2'b00, o8[k]}, {2'b00, exp_w[0][k]});
        check($sformatf("u4.I%0d", k), {2'b00, o4[k]}, {2'b00, exp_w[1][k]});
      end
      check("u8.wrap", {7'd0, w8}, {7'd0, exp_wrap[0]});
      check("u4.wrap", {7'd0, w4}, {7'd0, exp_wrap[1]});
    end
  end

  task automatic cyc(input logic i, input logic d, input logic c, input logic r);
    @(posedge clk);
    #1;
    inc_tick = i; dec_tick = d; clear = c; reset = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  localparam logic [5:0] BLANK0 =
`ifdef LEADING_ZERO_BLANK_EN
    6'b000000;
`else
    6'b100000;
`endif

  initial begin
    reset = 1; inc_tick = 0; dec_tick = 0; clear = 0; dp_mask = 8'h00;
    idle(0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    check("reset I0", {2'b00, o8[0]}, 8'b0010_0000);
    check("reset I1", {2'b00, o8[1]}, {2'b00, BLANK0});
    check("reset wrap", {7'd0, w8}, 8'd0);

    // Twelve increments.
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0);
    idle(3);
    @(negedge clk);
    check("12 inc I0", {2'b00, o8[0]}, 8'b0010_0100);
    check("12 inc I1", {2'b00, o8[1]}, 8'b0010_0010);
    check("12 inc I2", {2'b00, o8[2]}, {2'b00, BLANK0});

    // Underflow from 0: u4 -> 9999, u8 -> 99999999.
    cyc(0, 0, 1, 0);
    idle(2);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    check("underflow wrap hi", {6'd0, w4, w8}, 8'b0000_0011);
    @(negedge clk);
    check("underflow wrap lo", {6'd0, w4, w8}, 8'd0);
    check("9999 I3", {2'b00, o4[3]}, 8'b0011_0010);
    check("9999 I4", {2'b00, o4[4]}, 8'd0);
    check("9999 I7", {2'b00, o4[7]}, 8'd0);

    // Overflow of u8 from 99999999.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    check("overflow wrap", {7'd0, w8}, 8'd1);
    @(negedge clk);
    check("overflow I0", {2'b00, o8[0]}, 8'b0010_0000);
    check("overflow I7", {2'b00, o8[7]}, {2'b00, BLANK0});

    // Simultaneous inc/dec hold, then clear beats inc.
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 57; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    idle(3);
    @(negedge clk);
    check("hold 57 I0", {2'b00, o8[0]}, 8'b0010_1110);
    check("hold 57 I1", {2'b00, o8[1]}, 8'b0010_1010);
    cyc(1, 0, 1, 0);
    idle(3);
    @(negedge clk);
    check("clear+inc I0", {2'b00, o8[0]}, 8'b0010_0000);
    check("clear+inc I1", {2'b00, o8[1]}, {2'b00, BLANK0});

    // Decimal point on a blanked digit.
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    dp_mask = 8'b0000_0100;
    idle(2);
    @(negedge clk);
    check("dp I0", {2'b00, o8[0]}, 8'b0010_1010);
    check("dp I1", {2'b00, o8[1]}, {2'b00, BLANK0});
    check("dp I2", {2'b00, o8[2]}, 8'b0010_0001);
    dp_mask = 8'h00;

    // Reset while an output update is in flight.
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    check("midreset I0", {2'b00, o8[0]}, 8'b0010_0000);
    idle(2);
    @(negedge clk);
    check("midreset count", {2'b00, o8[0]}, 8'b0010_0000);

    // Randomised traffic, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      inc_tick = ($urandom_range(0, 2) == 0);
      dec_tick = ($urandom_range(0, 2) == 0);
      clear    = ($urandom_range(0, 63) == 0);
      reset    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) dp_mask = 8'($urandom);
    end
    idle(3);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_event_counter.md
# bcd_event_counter

Up/down decimal event counter that turns single-cycle edge pulses from the debounce/edge-detect FSMs into the eight 6-bit digit words consumed by the seven-segment driver. It keeps a DIGITS-wide BCD count, applies leading-zero blanking and a decimal-point mask, and registers the eight words so the driver's multiplexer sees a glitch-free image.

## Interface

Parameters:
- DIGITS, 8, number of active BCD decades (1..8). Words above DIGITS-1 are always blank.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- inc_tick  input  1  single-cycle increment request
- dec_tick  input  1  single-cycle decrement request
- clear  input  1  synchronous clear of the count to 0
- dp_mask  input  8  bit k sets the decimal point of digit k
- I0..I7  output  6 each  digit words: [5] digit enable, [4:1] BCD value, [0] decimal point (active-high; the driver inverts)
- wrap  output  1  one-cycle pulse on overflow or underflow

## Operation

- Count state: DIGITS BCD decades, d0 least significant. Every decade is always in the range 0..9.
- Per-cycle priority: reset > clear > (inc_tick XOR dec_tick). When inc_tick and dec_tick are both high, the count holds.
- Increment: d0+1. A decade at 9 becomes 0 and carries into the next decade.
- Decrement: d0-1. A decade at 0 becomes 9 and borrows from the next decade.
- Overflow: an all-9s count plus 1 goes to all 0s and asserts wrap.
- Underflow: an all-0s count minus 1 goes to all 9s and asserts wrap.
- clear forces all decades to 0 with no wrap pulse, even if a tick arrives in the same cycle.
- Word build, registered stage:
  - Ik[4:1] = dk for k < DIGITS, and 0 for k >= DIGITS.
  - Ik[0] = dp_mask[k] & (k < DIGITS).
  - Ik[5] is set by the blanking rules in Configuration. For k >= DIGITS it is always 0.
- Reset values:
  - Count is all 0.
  - I0 = 6'b100000: enabled, value 0, no DP.
  - I1..I7 = 0 with blanking enabled, or Ik[5]=1 for k < DIGITS with blanking disabled.
  - wrap = 0.

## Timing

- Tick sampled in cycle N:
  - Count updates at the edge ending cycle N.
  - wrap is high during cycle N+1 only.
  - I0..I7 reflect the new count in cycle N+2 (latency 2).
- dp_mask passes through the same output register stage, with latency 1.
- Back-to-back ticks in consecutive cycles are each counted. There is no throughput limit.
- Reset asserted mid-stream discards the in-flight output stage. Outputs take their reset values on the next edge.

## Configuration

- LEADING_ZERO_BLANK_EN
  - Defined: Ik[5]=1 only for k <= index of the most significant non-zero decade. I0 is always enabled, so a count of 0 shows a single "0". Ik[5]=1 regardless of value when dp_mask[k]=1 and k < DIGITS.
  - Not defined: Ik[5]=1 for every k < DIGITS, so leading zeros are shown.

## Structure

- Package sseg_pkg holds:
  - Word field positions: EN_BIT=5, HEX_MSB=4, HEX_LSB=1, DP_BIT=0.
  - Word width, WORD_W=6.
  - MAX_DIGITS=8.
  - The bcd_t typedef (4 bits).
- Sub-module bcd_decade contains one decade register. It has inputs en, up, cin (carry/borrow in) and clr, and outputs q[3:0] and cout (carry/borrow out).
  - Instantiate DIGITS copies with a generate loop, chaining cout into the next cin.
  - The final cout, qualified by a tick, produces wrap.

## Test plan

- Reset, then 12 inc_ticks with DIGITS=8 and blanking on -> I0 value 2 enabled, I1 value 1 enabled, I2..I7 enable=0; wrap never asserted.
- From count 0, one dec_tick with DIGITS=4 -> count 9999, wrap high for exactly 1 cycle, I4..I7 = 0.
- From count 99999999, one inc_tick -> all decades 0, wrap pulse, I0 = 6'b100000 two cycles after the tick.
- inc_tick and dec_tick together at count 57 -> count stays 57, no wrap. clear together with inc_tick -> count 0, no wrap.
- dp_mask=8'b0000_0100 at count 5 with blanking on -> I2 = 6'b100001 (enabled, value 0, DP set); I1 blank.
- Reset asserted while an output update is pending (inc_tick one cycle earlier) -> next cycle outputs equal reset values, count 0.
